// File: rtl/ald_valve_guard.sv
// Valve safety stage: SV1/SV4 interlock with break-before-make dead time,
// precursor on-time watchdog, and a latched purge fault (SVs shut, VVs open).
module ald_valve_guard #(
  parameter int unsigned DEAD_MS   = 5,
  parameter int unsigned MAX_ON_MS = 30000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       cmd_sv1,
  input  logic       cmd_sv4,
  input  logic       cmd_vv1,
  input  logic       cmd_vv2,
  input  logic       estop,
  input  logic       fault_clr,
  output logic       sv1_out,
  output logic       sv4_out,
  output logic       vv1_out,
  output logic       vv2_out,
  output logic       fault,
  output logic [1:0] fault_code
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_OPEN1 = 3'd1;
  localparam logic [2:0] ST_OPEN4 = 3'd2;
  localparam logic [2:0] ST_DEAD  = 3'd3;
  localparam logic [2:0] ST_FAULT = 3'd4;

  localparam logic [1:0] CODE_NONE     = 2'd0;
  localparam logic [1:0] CODE_CONFLICT = 2'd1;
  localparam logic [1:0] CODE_ESTOP    = 2'd2;
  localparam logic [1:0] CODE_WDOG     = 2'd3;

  logic [2:0]  state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [1:0]  code_reg, code_next;
  logic [31:0] cnt_wide;
  logic        conflict;
  logic        wdog_hit;
  logic        dead_done;
  logic        clear_ok;

  assign cnt_wide  = {16'd0, cnt_reg};
  assign conflict  = cmd_sv1 && cmd_sv4;
  assign wdog_hit  = ((state_reg == ST_OPEN1) || (state_reg == ST_OPEN4)) &&
                     (MAX_ON_MS != 0) && (cnt_wide >= MAX_ON_MS);
  assign dead_done = (cnt_wide >= DEAD_MS);
  assign clear_ok  = fault_clr && !estop && !cmd_sv1 && !cmd_sv4;

  always_comb begin
    state_next = state_reg;
    code_next  = code_reg;
    if (state_reg == ST_FAULT) begin
      if (clear_ok) begin
        state_next = ST_DEAD;
        code_next  = CODE_NONE;
      end
    end else if (estop) begin
      state_next = ST_FAULT;
      code_next  = CODE_ESTOP;
    end else if (conflict) begin
      state_next = ST_FAULT;
      code_next  = CODE_CONFLICT;
    end else if (wdog_hit) begin
      state_next = ST_FAULT;
      code_next  = CODE_WDOG;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (cmd_sv1)      state_next = ST_OPEN1;
          else if (cmd_sv4) state_next = ST_OPEN4;
        end
        ST_OPEN1: if (!cmd_sv1) state_next = ST_DEAD;
        ST_OPEN4: if (!cmd_sv4) state_next = ST_DEAD;
        ST_DEAD:  if (dead_done) state_next = ST_IDLE;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  // Counter restarts on every state change, so a tick on the entry cycle is dropped.
  always_comb begin
    cnt_next = cnt_reg;
    if (state_next != state_reg) begin
      cnt_next = 16'd0;
    end else if (tick && (cnt_reg != 16'hFFFF)) begin
      cnt_next = cnt_reg + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= 16'd0;
      code_reg   <= CODE_NONE;
      sv1_out    <= 1'b0;
      sv4_out    <= 1'b0;
      vv1_out    <= 1'b0;
      vv2_out    <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      code_reg   <= code_next;
      sv1_out    <= (state_next == ST_OPEN1);
      sv4_out    <= (state_next == ST_OPEN4);
      vv1_out    <= cmd_vv1 || (state_next == ST_FAULT);
      vv2_out    <= cmd_vv2 || (state_next == ST_FAULT);
      fault      <= (state_next == ST_FAULT);
    end
  end

  assign fault_code = code_reg;

endmodule

// File: tb/tb_ald_valve_guard.sv
// Bench for ald_valve_guard: two instances (guarded and watchdog/dead-time disabled)
// driven in lockstep and compared each cycle against a behavioural valve model.
module tb_ald_valve_guard;

  logic clk = 1'b0;
  logic rst, tick, cmd_sv1, cmd_sv4, cmd_vv1, cmd_vv2, estop, fault_clr;
  logic a_sv1, a_sv4, a_vv1, a_vv2, a_fault;
  logic b_sv1, b_sv4, b_vv1, b_vv2, b_fault;
  logic [1:0] a_code, b_code;

  int total = 0;
  int bad   = 0;
  int tick_period = 4;
  int tick_phase  = 0;
  bit tick_rand   = 1'b0;

  always #10 clk = ~clk;

  ald_valve_guard #(.DEAD_MS(5), .MAX_ON_MS(100)) u_a (
    .clk(clk), .rst(rst), .tick(tick), .cmd_sv1(cmd_sv1), .cmd_sv4(cmd_sv4),
    .cmd_vv1(cmd_vv1), .cmd_vv2(cmd_vv2), .estop(estop), .fault_clr(fault_clr),
    .sv1_out(a_sv1), .sv4_out(a_sv4), .vv1_out(a_vv1), .vv2_out(a_vv2),
    .fault(a_fault), .fault_code(a_code)
  );

  ald_valve_guard #(.DEAD_MS(0), .MAX_ON_MS(0)) u_b (
    .clk(clk), .rst(rst), .tick(tick), .cmd_sv1(cmd_sv1), .cmd_sv4(cmd_sv4),
    .cmd_vv1(cmd_vv1), .cmd_vv2(cmd_vv2), .estop(estop), .fault_clr(fault_clr),
    .sv1_out(b_sv1), .sv4_out(b_sv4), .vv1_out(b_vv1), .vv2_out(b_vv2),
    .fault(b_fault), .fault_code(b_code)
  );

  // Model: what the valves are doing, how many ticks since that began, latched code.
  localparam int M_IDLE = 0, M_OPEN1 = 1, M_OPEN4 = 2, M_DEAD = 3, M_FAULT = 4;
  int         m_mode[2];
  int         m_ticks[2];
  int         m_code[2];
  logic [6:0] m_out[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input int k, input int dead_ms, input int max_on);
    int nxt, code, held;
    if (rst) begin
      m_mode[k] = M_IDLE; m_ticks[k] = 0; m_code[k] = 0; m_out[k] = 7'd0;
      return;
    end
    nxt  = m_mode[k];
    code = m_code[k];
    held = (m_ticks[k] > 65535) ? 65535 : m_ticks[k];
    if (m_mode[k] == M_FAULT) begin
      if (fault_clr && !estop && !cmd_sv1 && !cmd_sv4) begin nxt = M_DEAD; code = 0; end
    end else if (estop) begin
      nxt = M_FAULT; code = 2;
    end else if (cmd_sv1 && cmd_sv4) begin
      nxt = M_FAULT; code = 1;
    end else if ((m_mode[k] == M_OPEN1 || m_mode[k] == M_OPEN4) && max_on != 0 && held >= max_on) begin
      nxt = M_FAULT; code = 3;
    end else if (m_mode[k] == M_IDLE) begin
      nxt = cmd_sv1 ? M_OPEN1 : (cmd_sv4 ? M_OPEN4 : M_IDLE);
    end else if (m_mode[k] == M_OPEN1 && !cmd_sv1) begin
      nxt = M_DEAD;
    end else if (m_mode[k] == M_OPEN4 && !cmd_sv4) begin
      nxt = M_DEAD;
    end else if (m_mode[k] == M_DEAD && held >= dead_ms) begin
      nxt = M_IDLE;
    end
    m_ticks[k] = (nxt != m_mode[k]) ? 0 : m_ticks[k] + (tick ? 1 : 0);
    m_mode[k]  = nxt;
    m_code[k]  = code;
    m_out[k]   = {nxt == M_OPEN1, nxt == M_OPEN4, cmd_vv1 || nxt == M_FAULT,
                  cmd_vv2 || nxt == M_FAULT, nxt == M_FAULT, 2'(code)};
  endtask

  task automatic cycle();
    tick = tick_rand ? ($urandom_range(0, 3) == 0) : ((tick_phase % tick_period) == 0);
    tick_phase++;
    @(posedge clk);
    model_step(0, 5, 100);
    model_step(1, 0, 0);
    @(negedge clk);
    check("outs_a", {25'd0, a_sv1, a_sv4, a_vv1, a_vv2, a_fault, a_code}, {25'd0, m_out[0]});
    check("outs_b", {25'd0, b_sv1, b_sv4, b_vv1, b_vv2, b_fault, b_code}, {25'd0, m_out[1]});
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; cmd_sv1 = 1'b0; cmd_sv4 = 1'b0; cmd_vv1 = 1'b0;
    cmd_vv2 = 1'b0; estop = 1'b0; fault_clr = 1'b0;
    @(negedge clk);
    run(3);
    check("reset_outs_a", {a_sv1, a_sv4, a_vv1, a_vv2, a_fault, a_code}, 0);
    rst = 1'b0;
    run(2);

    // Break-before-make: SV1 for 40 clk, SV4 requested right after the drop.
    cmd_sv1 = 1'b1; run(1);
    check("sv1_open", a_sv1, 1);
    run(39);
    cmd_sv1 = 1'b0; run(1);
    check("sv1_close", a_sv1, 0);
    cmd_sv4 = 1'b1; run(2);
    check("sv4_held_dead", a_sv4, 0);
    run(60);
    check("sv4_after_dead", a_sv4, 1);
    cmd_sv4 = 1'b0; run(40);

    // Simultaneous requests in IDLE.
    cmd_sv1 = 1'b1; cmd_sv4 = 1'b1; cmd_vv1 = 1'b0; cmd_vv2 = 1'b0; run(1);
    check("conflict_fault", a_fault, 1);
    check("conflict_code", a_code, 1);
    check("conflict_svs", {a_sv1, a_sv4}, 0);
    check("conflict_vvs", {a_vv1, a_vv2}, 3);
    cmd_sv1 = 1'b0; cmd_sv4 = 1'b0; fault_clr = 1'b1; run(1);
    fault_clr = 1'b0; run(40);
    check("conflict_cleared", {a_fault, a_code}, 0);

    // Watchdog on SV4; instance b has it disabled.
    cmd_sv4 = 1'b1; run(1);
    check("wd_open", a_sv4, 1);
    run(420);
    check("wd_fault", {a_fault, a_code, a_sv4}, {1'b1, 2'd3, 1'b0});
    check("wd_off_b", {b_sv4, b_fault}, 2'b10);
    fault_clr = 1'b1; run(10);
    check("wd_clr_cmd_high", a_fault, 1);
    cmd_sv4 = 1'b0; run(1);
    check("wd_cleared", {a_fault, a_code}, 0);
    run(40); fault_clr = 1'b0; run(2);

    // E-stop during OPEN1 together with a conflict.
    cmd_sv1 = 1'b1; run(5);
    cmd_sv4 = 1'b1; estop = 1'b1; run(1);
    check("estop_code", {a_fault, a_code, a_sv1}, {1'b1, 2'd2, 1'b0});
    fault_clr = 1'b1; run(5);
    check("estop_held", {a_fault, a_code}, {1'b1, 2'd2});
    cmd_sv1 = 1'b0; cmd_sv4 = 1'b0; estop = 1'b0; run(2);
    check("estop_cleared", {a_fault, a_code}, 0);
    fault_clr = 1'b0; run(40);

    // Reset while in FAULT, then immediate reopen.
    estop = 1'b1; run(2);
    check("pre_rst_vvs", {a_fault, a_vv1, a_vv2}, 3'b111);
    estop = 1'b0; rst = 1'b1; run(1);
    check("rst_in_fault", {a_sv1, a_sv4, a_vv1, a_vv2, a_fault, a_code}, 0);
    rst = 1'b0; run(1);
    cmd_sv1 = 1'b1; run(1);
    check("rst_reopen", a_sv1, 1);
    cmd_sv1 = 1'b0; run(40);

    // Randomized segments with jittered ticks.
    tick_rand = 1'b1;
    for (int s = 0; s < 80; s++) begin
      int r;
      r = $urandom_range(0, 99);
      cmd_sv1   = ($urandom_range(0, 2) == 0);
      cmd_sv4   = ($urandom_range(0, 2) == 0);
      cmd_vv1   = $urandom_range(0, 1);
      cmd_vv2   = $urandom_range(0, 1);
      estop     = ($urandom_range(0, 19) == 0);
      fault_clr = ($urandom_range(0, 3) == 0);
      run(r < 10 ? $urandom_range(400, 500) : $urandom_range(1, 30));
    end

    // Saturation with the watchdog disabled: tick every clk, SV1 held.
    tick_rand = 1'b0; tick_period = 1;
    cmd_sv1 = 1'b0; cmd_sv4 = 1'b0; cmd_vv1 = 1'b0; cmd_vv2 = 1'b0;
    estop = 1'b0; fault_clr = 1'b1; run(40);
    fault_clr = 1'b0; run(2);
    cmd_sv1 = 1'b1; run(66000);
    check("sat_sv1_b", {b_sv1, b_fault}, 2'b10);
    check("sat_cnt_b", u_b.cnt_reg, 16'hFFFF);
    check("sat_wd_a", {a_fault, a_code}, {1'b1, 2'd3});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
